// File: rtl/block_piso.sv
// Parallel-in / serial-out block serialiser: a WIDTH_IN block is emitted MSW first as
// WIDTH_OUT words. A new block can be loaded on the same edge as the last word leaves.
module block_piso #(
   parameter  int WIDTH_IN  = 128,
   parameter  int WIDTH_OUT = 32,
   localparam int N         = WIDTH_IN / WIDTH_OUT,
   localparam int CW        = $clog2(N) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH_IN-1:0]  din,
   input  logic [CW-1:0]        din_words,
   input  logic                 din_last,
   input  logic                 din_valid,
   output logic                 din_ready,
   output logic [WIDTH_OUT-1:0] dout,
   output logic                 dout_valid,
   output logic                 dout_last,
   input  logic                 dout_ready,
   output logic                 state_dbg
);

   // Handshake: a transfer happens on a rising clk edge where valid && ready are both 1;
   // valid never depends on ready, and a presented word holds until it is taken.

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [WIDTH_IN-1:0] sreg;
   logic                last_q;
   logic [CW-1:0]       words_eff;
   logic                in_xfer;
   logic                cnt_one;

   always_comb begin
      words_eff = (din_words > CW'(N)) ? CW'(N) : din_words;
   end

   assign cnt_one   = (cnt == CW'(1));
   assign din_ready = rst && ((state == IDLE) || (cnt_one && dout_ready));
   assign in_xfer   = din_valid && din_ready;

   assign dout       = sreg[WIDTH_IN-1 -: WIDTH_OUT];
   assign dout_valid = (state == SHIFT);
   assign dout_last  = last_q && cnt_one && (state == SHIFT);
   assign state_dbg  = (state == SHIFT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         sreg   <= '0;
         last_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Empty blocks are accepted and dropped without leaving IDLE.
               if (in_xfer && (words_eff != '0)) begin
                  sreg   <= din;
                  cnt    <= words_eff;
                  last_q <= din_last;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (dout_ready) begin
                  if (!cnt_one) begin
                     sreg <= sreg << WIDTH_OUT;
                     cnt  <= cnt - CW'(1);
                  end else if (in_xfer && (words_eff != '0)) begin
                     sreg   <= din;
                     cnt    <= words_eff;
                     last_q <= din_last;
                  end else begin
                     // Clearing the register keeps dout at zero while idle.
                     sreg   <= '0;
                     cnt    <= '0;
                     last_q <= 1'b0;
                     state  <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_block_piso.sv
// Randomised and directed bench for block_piso: a reference model expands every accepted
// block into its expected words; a monitor pops them as the DUT emits words.
module tb_block_piso;
   localparam int WI = 128;
   localparam int WO = 32;
   localparam int NW = WI / WO;

   logic          clk;
   logic          rst;
   logic [WI-1:0] din;
   logic [2:0]    din_words;
   logic          din_last;
   logic          din_valid;
   logic          din_ready;
   logic [WO-1:0] dout;
   logic          dout_valid;
   logic          dout_last;
   logic          dout_ready;
   logic          state_dbg;

   int checks   = 0;
   int failures = 0;
   logic [WO:0] exp_q[$];

   logic          hold_pending = 1'b0;
   logic [WO-1:0] hold_word;
   logic          hold_last;
   logic          rand_done;

   localparam logic [WI-1:0] BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;

   block_piso #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_words  (din_words),
      .din_last   (din_last),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_last  (dout_last),
      .dout_ready (dout_ready),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WO-1:0] word_of(input logic [WI-1:0] blk, input int i);
      logic [WI-1:0] t;
      t = blk >> (WO * (NW - 1 - i));
      return t[WO-1:0];
   endfunction

   // ---------------- reference model: expand accepted blocks ----------------
   always @(negedge clk) begin
      if (rst && din_valid && din_ready) begin
         int eff;
         eff = (int'(din_words) > NW) ? NW : int'(din_words);
         for (int i = 0; i < eff; i++)
            exp_q.push_back({din_last && (i == eff - 1), word_of(din, i)});
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            check("hold_valid", 64'(dout_valid), 64'(1));
            check("hold_data", 64'(dout), 64'(hold_word));
            check("hold_last", 64'(dout_last), 64'(hold_last));
         end
         if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 64'({dout_last, dout}), 64'(0) - 64'(1));
            end else begin
               logic [WO:0] e;
               e = exp_q.pop_front();
               check("word", 64'({dout_last, dout}), 64'(e));
            end
         end
         hold_pending = dout_valid && !dout_ready;
         hold_word    = dout;
         hold_last    = dout_last;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [WI-1:0] d, input logic [2:0] w, input logic l);
      int n;
      din = d; din_words = w; din_last = l; din_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!din_ready && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!din_ready) check("send_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
      din_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((dout_valid || exp_q.size() != 0) && n < 400) begin
         n++;
         @(negedge clk);
      end
      check("drain_timeout", 64'(dout_valid || exp_q.size() != 0), 64'(0));
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0; din = '0; din_words = '0; din_last = 1'b0;
      din_valid = 1'b0; dout_ready = 1'b0; rand_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 din_valid = 1'b1; dout_ready = 1'b1;
      @(negedge clk);
      check("rst_dout_valid", 64'(dout_valid), 64'(0));
      check("rst_dout", 64'(dout), 64'(0));
      check("rst_dout_last", 64'(dout_last), 64'(0));
      check("rst_din_ready", 64'(din_ready), 64'(0));
      @(posedge clk); #1;
      din_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("post_rst_din_ready", 64'(din_ready), 64'(1));
      @(posedge clk); #1;

      // Full block, four consecutive words
      dout_ready = 1'b1;
      send(BLK, 3'd4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("full_valid", 64'(dout_valid), 64'(1));
         check("full_data", 64'(dout), 64'(word_of(BLK, i)));
         check("full_last", 64'(dout_last), 64'(i == 3));
      end
      @(negedge clk);
      check("full_end_valid", 64'(dout_valid), 64'(0));
      wait_idle();

      // Partial block of two words
      send(BLK, 3'd2, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("part_data", 64'(dout), 64'(word_of(BLK, i)));
         check("part_last", 64'(dout_last), 64'(i == 1));
      end
      @(negedge clk);
      check("part_idle_valid", 64'(dout_valid), 64'(0));
      check("part_idle_ready", 64'(din_ready), 64'(1));
      wait_idle();

      // Backpressure on word 1
      send(BLK, 3'd4, 1'b0);
      @(negedge clk);
      check("bp_word0", 64'(dout), 64'(word_of(BLK, 0)));
      @(posedge clk); #1 dout_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid", 64'(dout_valid), 64'(1));
         check("bp_data", 64'(dout), 64'h44556677);
         check("bp_din_ready", 64'(din_ready), 64'(0));
      end
      @(posedge clk); #1 dout_ready = 1'b1;
      wait_idle();

      // Back-to-back blocks, no bubble
      din = BLK; din_words = 3'd4; din_last = 1'b0; din_valid = 1'b1;
      @(posedge clk); #1;
      din = ~BLK; din_last = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("b2b_valid", 64'(dout_valid), 64'(1));
         check("b2b_data", 64'(dout), 64'(word_of((i < 4) ? BLK : ~BLK, i % 4)));
         if (i < 4) check("b2b_din_ready", 64'(din_ready), 64'(i == 3));
         if (i == 3) begin
            @(posedge clk); #1 din_valid = 1'b0;
         end
      end
      wait_idle();

      // Empty blocks are swallowed
      din = BLK; din_words = 3'd0; din_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("empty_din_ready", 64'(din_ready), 64'(1));
         check("empty_no_valid", 64'(dout_valid), 64'(0));
         @(posedge clk); #1;
      end
      din_valid = 1'b0;
      @(negedge clk);
      check("empty_after_valid", 64'(dout_valid), 64'(0));
      @(posedge clk); #1;

      // Reset in the middle of a block
      send(BLK, 3'd4, 1'b1);
      @(negedge clk);
      check("mid_word0", 64'(dout), 64'(word_of(BLK, 0)));
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_din_ready", 64'(din_ready), 64'(0));
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 64'(dout_valid), 64'(0));
      check("mid_rst_dout", 64'(dout), 64'(0));
      check("mid_rst_last", 64'(dout_last), 64'(0));
      check("mid_rst_din_ready1", 64'(din_ready), 64'(1));
      @(posedge clk); #1;
      send(~BLK, 3'd3, 1'b1);
      @(negedge clk);
      check("after_rst_word0", 64'(dout), 64'(word_of(~BLK, 0)));
      wait_idle();

      // Random traffic, random backpressure, din_words up to 7
      fork
         begin
            for (int b = 0; b < 80; b++) begin
               send({$urandom, $urandom, $urandom, $urandom},
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               dout_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      dout_ready = 1'b1;
      wait_idle();
      check("queue_empty", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
